// File: rtl/mc_alu.sv
// mc_alu: signed ALU; add/sub/mul/pass finish in one cycle,
// div/rem run a WIDTH-cycle restoring divide on magnitudes, then fix up the sign.
module mc_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] C,
   output logic             Z,
   output logic             N,
   output logic             V,
   output logic             DZ
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
   state_t state, state_n;
   logic [WIDTH-1:0] qq, rr, dv, qn, rn, am, bm, sum, dif, imm_c, c_n;
   logic [WIDTH:0] sh, df;
   logic signed [2*WIDTH-1:0] prod;
   logic [CW-1:0] cnt;
   logic neg_q, neg_r, op_rem, ovf, acc, is_dr, ld;
   logic v_add, v_sub, v_mul, imm_v, v_n, dz_n;
   assign in_ready  = state == IDLE;
   assign out_valid = state == DONE;
   assign acc       = in_valid && in_ready;
   assign is_dr     = (sel == 3'd3 || sel == 3'd4) && B != '0;
   assign sum   = A + B;
   assign dif   = A - B;
   assign prod  = (2*WIDTH)'($signed(A)) * (2*WIDTH)'($signed(B));
   assign v_add = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
   assign v_sub = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
   // product fits only if the top WIDTH+1 bits are all sign copies
   assign v_mul = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
   assign am    = A[WIDTH-1] ? -A : A;
   assign bm    = B[WIDTH-1] ? -B : B;
   assign imm_c = sel == 3'd0 ? sum : sel == 3'd1 ? dif : sel == 3'd2 ? prod[WIDTH-1:0] :
                  sel == 3'd3 ? '1 : A;
   assign imm_v = sel == 3'd0 ? v_add : sel == 3'd1 ? v_sub : sel == 3'd2 ? v_mul : 1'b0;
   assign sh    = {rr, qq[WIDTH-1]};
   assign df    = sh - {1'b0, dv};
   assign qn    = {qq[WIDTH-2:0], ~df[WIDTH]};
   assign rn    = df[WIDTH] ? sh[WIDTH-1:0] : df[WIDTH-1:0];
   // the last iteration and the sign fix-up share one edge
   assign c_n   = state == DIV ? (op_rem ? (neg_r ? -rn : rn) : (neg_q ? -qn : qn)) : imm_c;
   assign v_n   = state == DIV ? ovf : imm_v;
   assign dz_n  = state == DIV ? 1'b0 : (sel == 3'd3 || sel == 3'd4);
   always_comb begin
      state_n = state;
      ld = 1'b0;
      case (state)
         IDLE: if (in_valid) begin
            state_n = is_dr ? DIV : DONE;
            ld = !is_dr;
         end
         DIV: if (cnt == LAST) begin
            state_n = DONE;
            ld = 1'b1;
         end
         default: if (out_ready) state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) state <= IDLE;
      else state <= state_n;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         {C, Z, N, V, DZ} <= '0;
         {qq, rr, dv, cnt, neg_q, neg_r, op_rem, ovf} <= '0;
      end else begin
         if (ld) begin
            C  <= c_n;
            Z  <= c_n == '0;
            N  <= c_n[WIDTH-1];
            V  <= v_n;
            DZ <= dz_n;
         end
         if (acc) begin
            qq     <= am;
            rr     <= '0;
            dv     <= bm;
            cnt    <= '0;
            neg_q  <= A[WIDTH-1] ^ B[WIDTH-1];
            neg_r  <= A[WIDTH-1];
            op_rem <= sel == 3'd4;
            ovf    <= sel == 3'd3 && A == MINV && B == '1;
         end else if (state == DIV) begin
            qq  <= qn;
            rr  <= rn;
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule
